// File: rtl/kim_alu_control_pipe_pkg.sv
// ---------------------------------------------------------------------------
// kim_alu_pkg
// Shared definitions for the ID/EX ALU control stage of the 32-bit MIPS core:
//   - main-decoder alu_op encodings (OP_*)
//   - R-type funct encodings (FN_*)
//   - ALU control codes driven into EX (CTRL_*)
//   - mult/div sequencer state enum and the decoder result struct
// ---------------------------------------------------------------------------
package kim_alu_pkg;

    // Main-decoder ALU op
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_LUI   = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    // R-type funct field
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    // ALU control codes
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_LUI  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;
    localparam logic [3:0] CTRL_SLTU = 4'b1011;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_XOR  = 4'b1101;
    localparam logic [3:0] CTRL_MFHI = 4'b1110;
    localparam logic [3:0] CTRL_MFLO = 4'b1111;

    // Mult/div sequencer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Decoder result
    typedef struct packed {
        logic [3:0] ctrl;     // ALU control code
        logic       is_md;    // mult or div
        logic       is_div;   // div (only meaningful with is_md)
        logic       is_hilo;  // mfhi or mflo
        logic       illegal;  // unsupported encoding
    } dec_t;

endpackage

// File: rtl/kim_alu_control_pipe_if.sv
// ---------------------------------------------------------------------------
// kim_alu_control_pipe_if
// ID-side request and EX-side result bundle of the ALU control stage.
//   master : ID stage / pipeline control (drives id_valid_in, flush_in,
//            alu_op_in, funct_in; observes everything else)
//   slave  : kim_alu_control_pipe
// Ports carried:
//   id_valid_in, flush_in, alu_op_in, funct_in        (ID -> stage)
//   ex_valid_out, alu_control, stall_out, md_start,
//   md_is_div, md_busy, hilo_we, illegal_out          (stage -> pipeline)
// ---------------------------------------------------------------------------
interface kim_alu_control_pipe_if #(
    parameter int ALU_OP_WIDTH = 3,
    parameter int FUNCT_WIDTH  = 6,
    parameter int CTRL_WIDTH   = 4
);
    logic                    id_valid_in;
    logic                    flush_in;
    logic [ALU_OP_WIDTH-1:0] alu_op_in;
    logic [FUNCT_WIDTH-1:0]  funct_in;
    logic                    ex_valid_out;
    logic [CTRL_WIDTH-1:0]   alu_control;
    logic                    stall_out;
    logic                    md_start;
    logic                    md_is_div;
    logic                    md_busy;
    logic                    hilo_we;
    logic                    illegal_out;

    modport master (
        output id_valid_in, flush_in, alu_op_in, funct_in,
        input  ex_valid_out, alu_control, stall_out, md_start,
               md_is_div, md_busy, hilo_we, illegal_out
    );

    modport slave (
        input  id_valid_in, flush_in, alu_op_in, funct_in,
        output ex_valid_out, alu_control, stall_out, md_start,
               md_is_div, md_busy, hilo_we, illegal_out
    );
endinterface

// File: rtl/kim_alu_control_pipe_decode.sv
// ---------------------------------------------------------------------------
// kim_alu_decode_p
// Purely combinational ALU control decode.
//   alu_op : main-decoder ALU op
//   funct  : instruction funct field (used when alu_op selects R-type)
//   dec    : {ctrl, is_md, is_div, is_hilo, illegal}
// Unsupported encodings decode to add with illegal set.
// ---------------------------------------------------------------------------
module kim_alu_decode_p
    import kim_alu_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3,
    parameter int FUNCT_WIDTH  = 6
) (
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    output dec_t                    dec
);

    logic [2:0] op;
    logic [5:0] fn;

    assign op = 3'(alu_op);
    assign fn = 6'(funct);

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // an output unassigned, which would otherwise infer a latch.
        dec      = '0;
        dec.ctrl = CTRL_ADD;
        case (op)
            OP_ADD:  dec.ctrl = CTRL_ADD;
            OP_SUB:  dec.ctrl = CTRL_SUB;
            OP_AND:  dec.ctrl = CTRL_AND;
            OP_OR:   dec.ctrl = CTRL_OR;
            OP_SLT:  dec.ctrl = CTRL_SLT;
            OP_LUI:  dec.ctrl = CTRL_LUI;
            OP_RSVD: dec.illegal = 1'b1;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_ADDU: dec.ctrl = CTRL_ADD;
                    FN_SUB, FN_SUBU: dec.ctrl = CTRL_SUB;
                    FN_AND:  dec.ctrl = CTRL_AND;
                    FN_OR:   dec.ctrl = CTRL_OR;
                    FN_XOR:  dec.ctrl = CTRL_XOR;
                    FN_NOR:  dec.ctrl = CTRL_NOR;
                    FN_SLT:  dec.ctrl = CTRL_SLT;
                    FN_SLTU: dec.ctrl = CTRL_SLTU;
                    FN_SLL:  dec.ctrl = CTRL_SLL;
                    FN_SRL:  dec.ctrl = CTRL_SRL;
                    FN_SRA:  dec.ctrl = CTRL_SRA;
                    FN_MFHI: begin
                        dec.ctrl    = CTRL_MFHI;
                        dec.is_hilo = 1'b1;
                    end
                    FN_MFLO: begin
                        dec.ctrl    = CTRL_MFLO;
                        dec.is_hilo = 1'b1;
                    end
                    FN_MULT: dec.is_md = 1'b1;
                    FN_DIV: begin
                        dec.is_md  = 1'b1;
                        dec.is_div = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/kim_alu_control_pipe.sv
// ---------------------------------------------------------------------------
// kim_alu_control_pipe
// Registered ALU control stage at the ID/EX boundary. Decodes alu_op/funct,
// registers the result into EX, sequences the multi-cycle mult/div unit and
// stalls ID/IF on HI/LO structural hazards.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : kim_alu_control_pipe_if.slave (ID request, EX results,
//                stall, mult/div handshake, HI/LO write enable, illegal flag)
// Build option: ALU_CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// encoding raises illegal_out while it sits in EX and is squashed
// (ex_valid_out=0); otherwise it executes as add and illegal_out stays 0.
// MUL_CYCLES and DIV_CYCLES must be >= 2; CNT_WIDTH must hold both.
// ---------------------------------------------------------------------------
module kim_alu_control_pipe
    import kim_alu_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3,
    parameter int FUNCT_WIDTH  = 6,
    parameter int CTRL_WIDTH   = 4,
    parameter int MUL_CYCLES   = 4,
    parameter int DIV_CYCLES   = 32,
    parameter int CNT_WIDTH    = 6
) (
    input logic                    clk,
    input logic                    rst_n,
    kim_alu_control_pipe_if.slave  bus
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    // Legacy build: illegal encodings run as add; the illegal register below
    // can only ever load 0, so illegal_out is constant 0.
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

    dec_t                 id_dec;
    logic                 ex_valid;
    logic [3:0]           ex_ctrl;
    logic                 ex_is_md;
    logic                 ex_is_div;
    logic                 ex_is_hilo;
    logic                 ex_illegal;
    md_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 stall;
    logic                 md_launch;

    kim_alu_decode_p #(
        .ALU_OP_WIDTH (ALU_OP_WIDTH),
        .FUNCT_WIDTH  (FUNCT_WIDTH)
    ) u_decode (
        .alu_op (bus.alu_op_in),
        .funct  (bus.funct_in),
        .dec    (id_dec)
    );

    // Only ops that touch HI/LO conflict with an in-flight mult/div.
    assign stall     = (state != IDLE) && ex_valid && (ex_is_md || ex_is_hilo);
    // A flushed mult/div in EX must not launch; one already running continues.
    assign md_launch = (state == IDLE) && ex_valid && ex_is_md && !bus.flush_in;

    // ---------------- EX register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_ADD;
            ex_is_md   <= 1'b0;
            ex_is_div  <= 1'b0;
            ex_is_hilo <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (bus.flush_in) begin
            ex_valid   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (!stall) begin
            ex_valid   <= bus.id_valid_in && !(TRAP_EN && id_dec.illegal);
            ex_ctrl    <= id_dec.ctrl;
            ex_is_md   <= id_dec.is_md;
            ex_is_div  <= id_dec.is_div;
            ex_is_hilo <= id_dec.is_hilo;
            ex_illegal <= TRAP_EN && bus.id_valid_in && id_dec.illegal;
        end
    end

    // ---------------- mult/div FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------- mult/div FSM: next state ----------------
    // Counter is loaded with latency-1 so that DONE (hilo_we) lands exactly
    // MUL_CYCLES / DIV_CYCLES cycles after the md_start cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (md_launch) begin
                    state_nxt = BUSY;
                    cnt_nxt   = ex_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_WIDTH'(1);
                if (cnt == CNT_WIDTH'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- mult/div FSM: outputs ----------------
    always_comb begin
        bus.md_start  = md_launch;
        bus.md_is_div = md_launch && ex_is_div;
        bus.md_busy   = (state != IDLE);
        bus.hilo_we   = (state == DONE);
    end

    assign bus.ex_valid_out = ex_valid;
    assign bus.alu_control  = CTRL_WIDTH'(ex_ctrl);
    assign bus.stall_out    = stall;
    assign bus.illegal_out  = ex_illegal;

endmodule

// File: tb/tb_kim_alu_control_pipe.sv
// ---------------------------------------------------------------------------
// tb_kim_alu_control_pipe
// Self-checking bench for kim_alu_control_pipe: a decode vector table run
// through a scoreboard queue, plus hand-written mult/div, flush, back-to-back
// and reset-during-BUSY sequences. Expectations follow the build option
// ALU_CTRL_ILLEGAL_TRAP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_kim_alu_control_pipe;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [2:0] alu_op;
        logic [5:0] funct;
        logic       valid;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [3:0] ctrl;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    kim_alu_control_pipe_if #(
        .ALU_OP_WIDTH (3),
        .FUNCT_WIDTH  (6),
        .CTRL_WIDTH   (4)
    ) bus ();

    kim_alu_control_pipe #(
        .ALU_OP_WIDTH (3),
        .FUNCT_WIDTH  (6),
        .CTRL_WIDTH   (4),
        .MUL_CYCLES   (MUL_CYCLES),
        .DIV_CYCLES   (DIV_CYCLES),
        .CNT_WIDTH    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
        bus.id_valid_in = v;
        bus.alu_op_in   = op;
        bus.funct_in    = fn;
    endtask

    task automatic settle_idle();
        drive(1'b0, 3'b000, 6'b000000);
        repeat (3) tick();
    endtask

    initial begin
        int stall_cnt, hilo_cnt, hilo_at, start_cnt, start_at;
        exp_t e, got;

        // alu_op / funct, valid, expected ctrl, illegal
        vecs.push_back('{3'b000, 6'b000000, 1'b1, 4'b0010, 1'b0});
        vecs.push_back('{3'b001, 6'b000000, 1'b1, 4'b0110, 1'b0});
        vecs.push_back('{3'b011, 6'b000000, 1'b1, 4'b0000, 1'b0});
        vecs.push_back('{3'b100, 6'b000000, 1'b1, 4'b0001, 1'b0});
        vecs.push_back('{3'b101, 6'b000000, 1'b1, 4'b0111, 1'b0});
        vecs.push_back('{3'b110, 6'b000000, 1'b1, 4'b0011, 1'b0});
        vecs.push_back('{3'b111, 6'b100100, 1'b1, 4'b0010, 1'b1});
        vecs.push_back('{3'b010, 6'b100000, 1'b1, 4'b0010, 1'b0});
        vecs.push_back('{3'b010, 6'b100001, 1'b1, 4'b0010, 1'b0});
        vecs.push_back('{3'b010, 6'b100010, 1'b1, 4'b0110, 1'b0});
        vecs.push_back('{3'b010, 6'b100011, 1'b1, 4'b0110, 1'b0});
        vecs.push_back('{3'b010, 6'b100100, 1'b1, 4'b0000, 1'b0});
        vecs.push_back('{3'b010, 6'b100101, 1'b1, 4'b0001, 1'b0});
        vecs.push_back('{3'b010, 6'b100110, 1'b1, 4'b1101, 1'b0});
        vecs.push_back('{3'b010, 6'b100111, 1'b1, 4'b1100, 1'b0});
        vecs.push_back('{3'b010, 6'b101010, 1'b1, 4'b0111, 1'b0});
        vecs.push_back('{3'b010, 6'b101011, 1'b1, 4'b1011, 1'b0});
        vecs.push_back('{3'b010, 6'b000000, 1'b1, 4'b1000, 1'b0});
        vecs.push_back('{3'b010, 6'b000010, 1'b1, 4'b1001, 1'b0});
        vecs.push_back('{3'b010, 6'b000011, 1'b1, 4'b1010, 1'b0});
        vecs.push_back('{3'b010, 6'b010000, 1'b1, 4'b1110, 1'b0});
        vecs.push_back('{3'b010, 6'b010010, 1'b1, 4'b1111, 1'b0});
        vecs.push_back('{3'b010, 6'b111111, 1'b1, 4'b0010, 1'b1});
        vecs.push_back('{3'b011, 6'b000000, 1'b0, 4'b0000, 1'b0});
        vecs.push_back('{3'b010, 6'b110101, 1'b0, 4'b0010, 1'b1});

        // ---------------- reset state ----------------
        rst_n        = 1'b0;
        bus.flush_in = 1'b0;
        drive(1'b0, 3'b000, 6'b000000);
        #12;
        check("rst ex_valid_out", bus.ex_valid_out, 0);
        check("rst alu_control",  bus.alu_control, 4'b0010);
        check("rst md_start",     bus.md_start, 0);
        check("rst md_is_div",    bus.md_is_div, 0);
        check("rst md_busy",      bus.md_busy, 0);
        check("rst hilo_we",      bus.hilo_we, 0);
        check("rst illegal_out",  bus.illegal_out, 0);
        check("rst stall_out",    bus.stall_out, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // ---------------- decode table through scoreboard ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].alu_op, vecs[i].funct);
            e.valid = vecs[i].valid && !(TRAP && vecs[i].ill);
            e.ctrl  = vecs[i].ctrl;
            e.ill   = TRAP && vecs[i].valid && vecs[i].ill;
            sb.push_back(e);
            tick();
            if (sb.size() == 0) begin
                check($sformatf("vec%0d scoreboard empty", i), 1, 0);
            end else begin
                got = sb.pop_front();
                check($sformatf("vec%0d ex_valid_out", i), bus.ex_valid_out, got.valid);
                check($sformatf("vec%0d alu_control", i),  bus.alu_control, got.ctrl);
                check($sformatf("vec%0d illegal_out", i),  bus.illegal_out, got.ill);
            end
        end

        // ---------------- reset mid-stream, then xor ----------------
        drive(1'b1, 3'b001, 6'b000000);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst ex_valid_out", bus.ex_valid_out, 0);
        check("midrst alu_control",  bus.alu_control, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'b010, 6'b100110);
        tick();
        check("xor ex_valid_out", bus.ex_valid_out, 1);
        check("xor alu_control",  bus.alu_control, 4'b1101);
        settle_idle();

        // ---------------- mult then mflo ----------------
        drive(1'b1, 3'b010, 6'b011000);
        tick();
        check("mult md_start",  bus.md_start, 1);
        check("mult md_is_div", bus.md_is_div, 0);
        drive(1'b1, 3'b010, 6'b010010);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        check("mflo in EX alu_control", bus.alu_control, 4'b1111);
        stall_cnt = 0; hilo_cnt = 0; hilo_at = -1; start_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            stall_cnt += int'(bus.stall_out);
            start_cnt += int'(bus.md_start);
            if (bus.hilo_we) begin
                hilo_cnt++;
                hilo_at = k;
            end
            if (k == MUL_CYCLES + 1) begin
                check("mflo accepted ex_valid_out", bus.ex_valid_out, 1);
                check("mflo accepted alu_control",  bus.alu_control, 4'b1111);
                check("mflo accepted stall_out",    bus.stall_out, 0);
            end
        end
        check("mult stall cycles", stall_cnt, MUL_CYCLES);
        check("mult hilo_we pulses", hilo_cnt, 1);
        check("mult hilo_we latency", hilo_at, MUL_CYCLES);
        check("mult no extra md_start", start_cnt, 0);
        check("mult md_busy idle", bus.md_busy, 0);
        settle_idle();

        // ---------------- back-to-back mult ----------------
        drive(1'b1, 3'b010, 6'b011000);
        tick();
        check("b2b first md_start", bus.md_start, 1);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        start_cnt = 0; start_at = -1; stall_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            stall_cnt += int'(bus.stall_out);
            if (bus.md_start) begin
                start_cnt++;
                if (start_at < 0) start_at = k;
                check("b2b second md_is_div", bus.md_is_div, 0);
            end
        end
        check("b2b second start cycle", start_at, MUL_CYCLES + 1);
        check("b2b start count", start_cnt, 1);
        check("b2b stall cycles", stall_cnt, MUL_CYCLES);
        check("b2b md_busy idle", bus.md_busy, 0);
        settle_idle();

        // ---------------- div then flush while BUSY ----------------
        drive(1'b1, 3'b010, 6'b011010);
        tick();
        check("div md_start",  bus.md_start, 1);
        check("div md_is_div", bus.md_is_div, 1);
        drive(1'b1, 3'b010, 6'b010000);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        check("div mfhi stall_out", bus.stall_out, 1);
        check("div mfhi alu_control", bus.alu_control, 4'b1110);
        tick();
        tick();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        check("flush ex_valid_out", bus.ex_valid_out, 0);
        check("flush stall_out", bus.stall_out, 0);
        check("flush md_busy", bus.md_busy, 1);
        hilo_at = -1; hilo_cnt = 0;
        for (int k = 4; k <= DIV_CYCLES + 4; k++) begin
            if (k > 4) tick();
            if (bus.hilo_we) begin
                hilo_cnt++;
                if (hilo_at < 0) hilo_at = k;
            end
        end
        check("div hilo_we latency", hilo_at, DIV_CYCLES);
        check("div hilo_we pulses", hilo_cnt, 1);
        check("div md_busy idle", bus.md_busy, 0);
        settle_idle();

        // ---------------- reset during BUSY ----------------
        drive(1'b1, 3'b010, 6'b011000);
        tick();
        drive(1'b1, 3'b010, 6'b010010);
        tick();
        drive(1'b0, 3'b000, 6'b000000);
        check("pre-rst md_busy", bus.md_busy, 1);
        check("pre-rst stall_out", bus.stall_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("busy-rst md_busy", bus.md_busy, 0);
        check("busy-rst stall_out", bus.stall_out, 0);
        check("busy-rst ex_valid_out", bus.ex_valid_out, 0);
        hilo_cnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1 hilo_cnt += int'(bus.hilo_we);
        end
        @(negedge clk) rst_n = 1'b1;
        start_cnt = 0;
        for (int k = 0; k < MUL_CYCLES + 4; k++) begin
            tick();
            hilo_cnt  += int'(bus.hilo_we);
            start_cnt += int'(bus.md_start);
        end
        check("busy-rst hilo_we never", hilo_cnt, 0);
        check("busy-rst no md_start", start_cnt, 0);
        check("busy-rst md_busy after", bus.md_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kim_alu_control_pipe.md
Name: kim_alu_control_pipe

Overview:
- Registered, parametrised ALU control stage for the 32-bit pipelined MIPS core; sits at the ID/EX boundary.
- Decodes alu_op plus funct into an ALU control code, covering immediate ops, shifts, unsigned ops and HI/LO moves.
- Registers the result into the EX stage.
- Sequences the multi-cycle mult/div unit with a busy FSM, and raises a pipeline stall on HI/LO structural hazards.

Parameters:
- ALU_OP_WIDTH, 3, width of alu_op_in.
- FUNCT_WIDTH, 6, width of funct_in.
- CTRL_WIDTH, 4, width of alu_control.
- MUL_CYCLES, 4, mult latency in cycles, must be >=2.
- DIV_CYCLES, 32, div latency in cycles, must be >=2.
- CNT_WIDTH, 6, busy counter width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_in  in  1  ID stage holds a valid instruction.
- flush_in  in  1  squash EX-stage contents.
- alu_op_in  in  ALU_OP_WIDTH  main-decoder ALU op.
- funct_in  in  FUNCT_WIDTH  instruction funct field.
- ex_valid_out  out  1  EX register holds a valid instruction.
- alu_control  out  CTRL_WIDTH  registered ALU control code.
- stall_out  out  1  hold ID/IF; combinational from registers.
- md_start  out  1  one-cycle pulse that launches the mult/div unit.
- md_is_div  out  1  qualifies md_start: 1 = div, 0 = mult.
- md_busy  out  1  mult/div FSM is not IDLE.
- hilo_we  out  1  one-cycle HI/LO write enable.
- illegal_out  out  1  registered unsupported-encoding flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): ex_valid_out=0, alu_control=0010, md_start=0, md_is_div=0, md_busy=0, hilo_we=0, illegal_out=0, FSM=IDLE, counter=0.
- alu_op decode:
  - 000 add (0010), 001 sub (0110), 010 R-type via funct, 011 and (0000), 100 or (0001), 101 slt (0111), 110 lui (0011).
  - 111 reserved: add, marked illegal.
- funct decode:
  - 100000/100001 add 0010; 100010/100011 sub 0110; 100100 and 0000; 100101 or 0001; 100110 xor 1101; 100111 nor 1100.
  - 101010 slt 0111; 101011 sltu 1011; 000000 sll 1000; 000010 srl 1001; 000011 sra 1010.
  - 010000 mfhi 1110; 010010 mflo 1111; 011000 mult 0010 + md op; 011010 div 0010 + md op.
  - Any other funct: add 0010, marked illegal.
- Capture: on each clk edge with stall_out=0, the EX register loads the decode and ex_valid_out<=id_valid_in. Latency is 1 cycle.
- Flush: flush_in=1 forces ex_valid_out<=0 next edge, overriding both capture and hold. Flush never aborts an in-flight mult/div.
- stall_out=1 when the FSM is not IDLE and the valid EX instruction is mult, div, mfhi or mflo. While stalled, the EX register holds its value.
- FSM states:
  - IDLE: a valid mult/div in EX (no flush) gives md_start=1 and md_is_div per op, loads counter=MUL_CYCLES-1 or DIV_CYCLES-1, then goes to BUSY.
  - BUSY: counter decrements each cycle; at counter==1 go to DONE.
  - DONE: hilo_we=1 for exactly 1 cycle, then IDLE. A stalled HI/LO op in EX is accepted on the IDLE cycle that follows.
- md_start and hilo_we are single-cycle pulses. md_busy=1 in BUSY and DONE.
- Back-to-back mult/div: the second op stalls until FSM=IDLE, then starts on that cycle. No gap beyond DONE→IDLE.
- Reset asserted mid-BUSY: immediate return to IDLE, no hilo_we.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal encoding sets illegal_out=1 for the cycle it sits valid in EX, and forces ex_valid_out=0 so the op is squashed. An illegal encoding never starts the FSM.
- Undefined: illegal_out is tied 0 and illegal encodings silently execute as add (legacy behaviour).

Decomposition:
- Package kim_alu_pkg holds: alu_op codes, funct codes, CTRL_* control codes, FSM state enum {IDLE, BUSY, DONE}.
- One sub-module, kim_alu_decode_p: purely combinational alu_op/funct → {ctrl, is_md, is_div, is_hilo, illegal}.
- The top level holds the EX register, counter and FSM.

Test Plan:
- Reset mid-stream, then alu_op=010, funct=100110, valid → next cycle ex_valid_out=1, alu_control=1101.
- alu_op=011 / 100 / 101 / 110 → alu_control 0000 / 0001 / 0111 / 0011, each one cycle after capture.
- mult then mflo on consecutive cycles (MUL_CYCLES=4):
  - md_start=1 with md_is_div=0.
  - stall_out=1 for 4 cycles.
  - hilo_we pulses once, then mflo captured with alu_control=1111.
- div then flush_in while BUSY → ex_valid_out=0, FSM continues; hilo_we fires DIV_CYCLES cycles after md_start.
- rst_n low during BUSY → md_busy=0 and stall_out=0 immediately; hilo_we never asserted.
- funct=111111 with ALU_CTRL_ILLEGAL_TRAP_EN defined → illegal_out=1, ex_valid_out=0. Undefined → alu_control=0010, ex_valid_out=1.
